fp_to_int: RTL and testbench

- Pipelined IEEE-754 float-to-signed-integer converter; the decode-side counterpart of the fp16 add/pack datapath.
- Leaves the floating-point domain: fp results → integer consumers such as index/address logic and fixed-point DSP.
- 3-stage pipeline with valid/ready handshake and global stall.
- Selectable rounding, IEEE saturation and exception flags.

---
 rtl/fp_pkg.sv | 33 +++
 rtl/fp_unpack.sv | 48 ++++
 rtl/fp_to_int.sv | 177 +++++++++++++++++
 tb/tb_fp_to_int.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared IEEE-754 helpers for the floating-point datapath: format geometry,
// rounding-mode codes and operand classes.
package fp_pkg;

  localparam logic RND_RNE = 1'b0;
  localparam logic RND_RTZ = 1'b1;

  typedef enum logic [2:0] {
    FP_ZERO,
    FP_DENORM,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_e;

  function automatic int fp_exp_w(input int width);
    case (width)
      16:      return 5;
      32:      return 8;
      64:      return 11;
      default: return 8;
    endcase
  endfunction

  function automatic int fp_bias(input int width);
    return (1 << (fp_exp_w(width) - 1)) - 1;
  endfunction

  function automatic int fp_mant_w(input int width);
    return width - 1 - fp_exp_w(width);
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational IEEE-754 operand decode: class, sign, unbiased exponent and
// significand with the hidden bit restored.
module fp_unpack
  import fp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]                 a,
  output logic                             sign,
  output fp_class_e                        cls,
  output logic signed [fp_exp_w(WIDTH):0]  e,
  output logic [fp_mant_w(WIDTH):0]        sig
);

  localparam int EXP_W  = fp_exp_w(WIDTH);
  localparam int MANT_W = fp_mant_w(WIDTH);
  localparam int BIAS   = fp_bias(WIDTH);

  localparam logic signed [EXP_W:0] BIAS_E   = (EXP_W + 1)'(BIAS);
  localparam logic signed [EXP_W:0] DENORM_E = (EXP_W + 1)'(1 - BIAS);

  logic [EXP_W-1:0]  exp_f;
  logic [MANT_W-1:0] mant;
  logic              exp_zero;
  logic              exp_ones;
  logic              mant_zero;

  assign exp_f     = a[WIDTH-2 -: EXP_W];
  assign mant      = a[MANT_W-1:0];
  assign sign      = a[WIDTH-1];
  assign exp_zero  = (exp_f == '0);
  assign exp_ones  = &exp_f;
  assign mant_zero = (mant == '0);

  // Denormals sit at the smallest normal exponent but without the hidden bit.
  assign e   = exp_zero ? DENORM_E : ($signed({1'b0, exp_f}) - BIAS_E);
  assign sig = {!exp_zero, mant};

  always_comb begin
    cls = FP_NORM;
    if (exp_zero) begin
      cls = mant_zero ? FP_ZERO : FP_DENORM;
    end else if (exp_ones) begin
      cls = mant_zero ? FP_INF : FP_NAN;
    end
  end

endmodule

// File: rtl/fp_to_int.sv
// Three-stage IEEE-754 to signed integer converter (unpack, align,
// round/saturate) with valid/ready handshake and a global stall.
module fp_to_int
  import fp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int INT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic             rnd_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] result,
  output logic             flag_invalid,
  output logic             flag_inexact
);

  localparam int EXP_W  = fp_exp_w(WIDTH);
  localparam int MANT_W = fp_mant_w(WIDTH);
  localparam int RW     = 2 * MANT_W + 3;

  localparam logic [INT_W:0]   POS_LIMIT = {2'b00, {(INT_W-1){1'b1}}};
  localparam logic [INT_W:0]   NEG_LIMIT = {2'b01, {(INT_W-1){1'b0}}};
  localparam logic [INT_W-1:0] SAT_POS   = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] SAT_NEG   = {1'b1, {(INT_W-1){1'b0}}};

  logic en;

  logic                   u_sign;
  fp_class_e              u_cls;
  logic signed [EXP_W:0]  u_e;
  logic [MANT_W:0]        u_sig;

  logic                   s1_valid;
  logic                   s1_sign;
  logic                   s1_rnd;
  fp_class_e              s1_cls;
  logic signed [EXP_W:0]  s1_e;
  logic [MANT_W:0]        s1_sig;

  int                     e_i;
  int                     ls_i;
  int                     rs_i;
  logic [INT_W-1:0]       lwide;
  logic [RW-1:0]          rwide;
  logic [INT_W-1:0]       al_mag;
  logic                   al_guard;
  logic                   al_sticky;
  logic                   al_ovf;

  logic                   s2_valid;
  logic                   s2_sign;
  logic                   s2_rnd;
  fp_class_e              s2_cls;
  logic [INT_W-1:0]       s2_mag;
  logic                   s2_guard;
  logic                   s2_sticky;
  logic                   s2_ovf;

  logic                   inc;
  logic [INT_W:0]         rmag;
  logic [INT_W-1:0]       nx_result;
  logic                   nx_invalid;
  logic                   nx_inexact;

  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  fp_unpack #(
    .WIDTH(WIDTH)
  ) u_unpack (
    .a    (a),
    .sign (u_sign),
    .cls  (u_cls),
    .e    (u_e),
    .sig  (u_sig)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_sign  <= u_sign;
      s1_rnd   <= rnd_mode;
      s1_cls   <= u_cls;
      s1_e     <= u_e;
      s1_sig   <= u_sig;
    end
  end

  // Shift amounts are clamped so the shifters stay operand-sized; anything
  // beyond the clamp is either overflow or pure sticky.
  always_comb begin
    e_i  = int'(s1_e);
    ls_i = e_i - MANT_W;
    if (ls_i < 0) ls_i = 0;
    if (ls_i > INT_W - 1) ls_i = INT_W - 1;
    rs_i = MANT_W - e_i;
    if (rs_i < 0) rs_i = 0;
    if (rs_i > MANT_W + 2) rs_i = MANT_W + 2;

    lwide  = INT_W'(s1_sig) << ls_i;
    rwide  = {s1_sig, {(MANT_W+2){1'b0}}} >> rs_i;
    al_ovf = (e_i >= INT_W);

    if (e_i >= MANT_W) begin
      al_mag    = lwide;
      al_guard  = 1'b0;
      al_sticky = 1'b0;
    end else begin
      al_mag    = INT_W'(rwide[RW-1:MANT_W+2]);
      al_guard  = rwide[MANT_W+1];
      al_sticky = |rwide[MANT_W:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else if (en) begin
      s2_valid  <= s1_valid;
      s2_sign   <= s1_sign;
      s2_rnd    <= s1_rnd;
      s2_cls    <= s1_cls;
      s2_mag    <= al_mag;
      s2_guard  <= al_guard;
      s2_sticky <= al_sticky;
      s2_ovf    <= al_ovf;
    end
  end

  // The negative range reaches one further than the positive range, so
  // -2^(INT_W-1) passes while +2^(INT_W-1) saturates.
  always_comb begin
    inc        = (s2_rnd == RND_RNE) && s2_guard && (s2_sticky || s2_mag[0]);
    rmag       = {1'b0, s2_mag} + (INT_W + 1)'(inc);
    nx_result  = '0;
    nx_invalid = 1'b0;
    nx_inexact = 1'b0;
    if (s2_cls == FP_NAN) begin
      nx_result  = SAT_POS;
      nx_invalid = 1'b1;
    end else if (s2_cls == FP_INF) begin
      nx_result  = s2_sign ? SAT_NEG : SAT_POS;
      nx_invalid = 1'b1;
    end else if (s2_ovf || (!s2_sign && (rmag > POS_LIMIT)) ||
                 (s2_sign && (rmag > NEG_LIMIT))) begin
      nx_result  = s2_sign ? SAT_NEG : SAT_POS;
      nx_invalid = 1'b1;
    end else begin
      nx_result  = s2_sign ? (~rmag[INT_W-1:0] + INT_W'(1)) : rmag[INT_W-1:0];
      nx_inexact = s2_guard || s2_sticky;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      result       <= '0;
      flag_invalid <= 1'b0;
      flag_inexact <= 1'b0;
    end else if (en) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        result       <= nx_result;
        flag_invalid <= nx_invalid;
        flag_inexact <= nx_inexact;
      end
    end
  end

endmodule

// File: tb/tb_fp_to_int.sv
// Directed self-checking bench for fp_to_int: single conversions on three
// parameterisations, a stalled back-to-back stream and reset during a stall.
module tb_fp_to_int;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a_in;
  logic        rnd;
  logic        out_rdy;
  logic        iv0, iv1, iv2;
  logic        ir0, ir1, ir2;
  logic        ov0, ov1, ov2;
  logic        inv0, inv1, inv2;
  logic        inx0, inx1, inx2;
  logic [15:0] r0;
  logic [31:0] r1;
  logic [31:0] r2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_to_int #(.WIDTH(16), .INT_W(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a_in[15:0]),
    .rnd_mode(rnd), .out_valid(ov0), .out_ready(out_rdy), .result(r0),
    .flag_invalid(inv0), .flag_inexact(inx0)
  );

  fp_to_int #(.WIDTH(16), .INT_W(32)) dut1632 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a_in[15:0]),
    .rnd_mode(rnd), .out_valid(ov1), .out_ready(out_rdy), .result(r1),
    .flag_invalid(inv1), .flag_inexact(inx1)
  );

  fp_to_int #(.WIDTH(32), .INT_W(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a_in),
    .rnd_mode(rnd), .out_valid(ov2), .out_ready(out_rdy), .result(r2),
    .flag_invalid(inv2), .flag_inexact(inx2)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; presents one operand and waits for its result.
  task automatic applyStimulus(input int sel, input logic [31:0] av, input logic rm,
                               output logic [63:0] res, output logic [1:0] flg,
                               output int lat);
    res = '0;
    flg = '0;
    lat = -1;
    a_in = av;
    rnd = rm;
    out_rdy = 1'b1;
    case (sel)
      0:       iv0 = 1'b1;
      1:       iv1 = 1'b1;
      default: iv2 = 1'b1;
    endcase
    @(posedge clk);
    #1;
    iv0 = 1'b0;
    iv1 = 1'b0;
    iv2 = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      case (sel)
        0: if (ov0) begin lat = n; res = 64'(r0); flg = {inv0, inx0}; end
        1: if (ov1) begin lat = n; res = 64'(r1); flg = {inv1, inx1}; end
        default: if (ov2) begin lat = n; res = 64'(r2); flg = {inv2, inx2}; end
      endcase
      if (lat >= 0) break;
    end
  endtask

  task automatic runVector(input string tag, input int sel, input logic [31:0] av,
                           input logic rm, input logic [63:0] exp_res,
                           input logic [1:0] exp_flg);
    logic [63:0] res;
    logic [1:0]  flg;
    int          lat;
    applyStimulus(sel, av, rm, res, flg, lat);
    checkOutput({tag, "_lat"}, 64'(lat), 64'(3));
    checkOutput({tag, "_res"}, res, exp_res);
    checkOutput({tag, "_flags"}, 64'(flg), 64'(exp_flg));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] tbl [20];
    logic        pat [4];
    int          tx, rx, c, acc_cyc, first_out;
    logic        mv1, mv2, mv3, en_m, acc;
    logic [15:0] md1, md2, md3;

    tbl = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500,
            16'h4600, 16'h4700, 16'h4800, 16'h4880, 16'h4900,
            16'h4980, 16'h4A00, 16'h4A80, 16'h4B00, 16'h4B80,
            16'h4C00, 16'h4C40, 16'h4C80, 16'h4CC0, 16'h4D00};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    iv0 = 1'b0;
    iv1 = 1'b0;
    iv2 = 1'b0;
    a_in = '0;
    rnd = 1'b0;
    out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid16", 64'(ov0), 64'(0));
    checkOutput("rst_result16", 64'(r0), 64'(0));
    checkOutput("rst_flags16", 64'({inv0, inx0}), 64'(0));
    checkOutput("rst_out_valid1632", 64'(ov1), 64'(0));
    checkOutput("rst_out_valid32", 64'(ov2), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready16", 64'(ir0), 64'(1));
    checkOutput("rst_in_ready1632", 64'(ir1), 64'(1));
    checkOutput("rst_in_ready32", 64'(ir2), 64'(1));

    $display("[TB] directed conversions, fp16 -> int16");
    runVector("p1_5_rne",   0, 32'h3E00, 1'b0, 64'h0002, 2'b01);
    runVector("p1_5_rtz",   0, 32'h3E00, 1'b1, 64'h0001, 2'b01);
    runVector("p2_5_rne",   0, 32'h4100, 1'b0, 64'h0002, 2'b01);
    runVector("n2_5_rne",   0, 32'hC100, 1'b0, 64'hFFFE, 2'b01);
    runVector("n5_0",       0, 32'hC500, 1'b0, 64'hFFFB, 2'b00);
    runVector("neg_zero",   0, 32'h8000, 1'b0, 64'h0000, 2'b00);
    runVector("min_denorm", 0, 32'h0001, 1'b0, 64'h0000, 2'b01);
    runVector("one",        0, 32'h3C00, 1'b0, 64'h0001, 2'b00);
    runVector("n0_4",       0, 32'hB666, 1'b0, 64'h0000, 2'b01);
    runVector("p0_75_rne",  0, 32'h3A00, 1'b0, 64'h0001, 2'b01);
    runVector("p0_75_rtz",  0, 32'h3A00, 1'b1, 64'h0000, 2'b01);
    runVector("p0_5_tie",   0, 32'h3800, 1'b0, 64'h0000, 2'b01);
    runVector("p32752",     0, 32'h77FF, 1'b0, 64'h7FF0, 2'b00);
    runVector("n32768",     0, 32'hF800, 1'b0, 64'h8000, 2'b00);
    runVector("p32768",     0, 32'h7800, 1'b0, 64'h7FFF, 2'b10);
    runVector("max_half",   0, 32'h7BFF, 1'b0, 64'h7FFF, 2'b10);
    runVector("min_half",   0, 32'hFBFF, 1'b0, 64'h8000, 2'b10);
    runVector("pos_inf",    0, 32'h7C00, 1'b0, 64'h7FFF, 2'b10);
    runVector("neg_inf",    0, 32'hFC00, 1'b0, 64'h8000, 2'b10);
    runVector("qnan",       0, 32'h7E00, 1'b0, 64'h7FFF, 2'b10);
    runVector("neg_nan",    0, 32'hFE00, 1'b1, 64'h7FFF, 2'b10);

    $display("[TB] directed conversions, fp16 -> int32 and fp32 -> int32");
    runVector("w_max_half", 1, 32'h7BFF, 1'b0, 64'h0000FFE0, 2'b00);
    runVector("w_min_half", 1, 32'hFBFF, 1'b0, 64'hFFFF0020, 2'b00);
    runVector("s_n2p31",    2, 32'hCF000000, 1'b0, 64'h80000000, 2'b00);
    runVector("s_p2p31",    2, 32'h4F000000, 1'b0, 64'h7FFFFFFF, 2'b10);
    runVector("s_big",      2, 32'h4EFFFFFF, 1'b0, 64'h7FFFFF80, 2'b00);
    runVector("s_1_5_rtz",  2, 32'h3FC00000, 1'b1, 64'h00000001, 2'b01);

    $display("[TB] back-to-back stream with out_ready pattern 1,0,0,1");
    tx = 0;
    rx = 0;
    c = 0;
    acc_cyc = -1;
    first_out = -1;
    mv1 = 1'b0; mv2 = 1'b0; mv3 = 1'b0;
    md1 = '0;   md2 = '0;   md3 = '0;
    rnd = 1'b0;
    while (rx < 20 && c < 200) begin
      out_rdy = pat[c % 4];
      iv0 = (tx < 20);
      a_in = (tx < 20) ? {16'h0000, tbl[tx]} : 32'h0;
      #1;
      en_m = !(mv3 && !out_rdy);
      checkOutput("stream_in_ready", 64'(ir0), 64'(en_m));
      checkOutput("stream_out_valid", 64'(ov0), 64'(mv3));
      if (mv3) begin
        checkOutput("stream_result", 64'(r0), 64'(md3));
        checkOutput("stream_flags", 64'({inv0, inx0}), 64'(0));
      end
      if (ov0 && first_out < 0) first_out = c;
      acc = iv0 && en_m;
      if (acc && acc_cyc < 0) acc_cyc = c;
      if (mv3 && out_rdy) rx++;
      @(posedge clk);
      if (en_m) begin
        mv3 = mv2; md3 = md2;
        mv2 = mv1; md2 = md1;
        mv1 = acc; md1 = 16'(tx + 1);
      end
      if (acc) tx++;
      @(negedge clk);
      c++;
    end
    iv0 = 1'b0;
    checkOutput("stream_count", 64'(rx), 64'(20));
    checkOutput("stream_first_latency", 64'(first_out - acc_cyc), 64'(3));

    $display("[TB] reset while stalled");
    out_rdy = 1'b0;
    a_in = 32'h4200;
    iv0 = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("stall_out_valid", 64'(ov0), 64'(1));
    checkOutput("stall_result", 64'(r0), 64'(3));
    checkOutput("stall_in_ready", 64'(ir0), 64'(0));
    rst = 1'b1;
    iv0 = 1'b0;
    @(negedge clk);
    checkOutput("midrst_out_valid", 64'(ov0), 64'(0));
    checkOutput("midrst_result", 64'(r0), 64'(0));
    checkOutput("midrst_flags", 64'({inv0, inx0}), 64'(0));
    rst = 1'b0;
    #1;
    checkOutput("midrst_in_ready", 64'(ir0), 64'(1));
    a_in = 32'h4500;
    out_rdy = 1'b1;
    iv0 = 1'b1;
    @(posedge clk);
    #1;
    iv0 = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      checkOutput($sformatf("post_rst_valid_c%0d", n), 64'(ov0), 64'(n == 3));
    end
    checkOutput("post_rst_result", 64'(r0), 64'h0005);
    checkOutput("post_rst_flags", 64'({inv0, inx0}), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
